// File: rtl/s7_iserdes_pkg.sv
`default_nettype none
// ============================================================================
// s7_iserdes_pkg : training FSM states and default constants for s7_iserdes
// Revision       : 1.0
// ============================================================================
package s7_iserdes_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ZERO   = 3'd1,
    S_SCAN   = 3'd2,
    S_CENTER = 3'd3,
    S_SLIP   = 3'd4,
    S_WAIT   = 3'd5,
    S_NEXT   = 3'd6
  } state_t;

  localparam logic [7:0] DEF_PATTERN  = 8'hF0;
  localparam int         DEF_TAP_BITS = 5;
  localparam int         DEF_SETTLE   = 16;

endpackage
`default_nettype wire

// File: rtl/s7_iserdes_eye_scan.sv
`default_nettype none
// ============================================================================
// s7_iserdes_eye_scan : per-tap word stability check and first-window tracker
// Revision            : 1.0
// ============================================================================
module s7_iserdes_eye_scan
  import s7_iserdes_pkg::*;
#(
  parameter int DW       = 8,
  parameter int TAP_BITS = DEF_TAP_BITS,
  parameter int SAMPLES  = 64
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic                clear_i,
  input  logic                valid_i,
  input  logic [DW-1:0]       word_i,
  input  logic [TAP_BITS-1:0] tap_i,
  output logic                done_o,
  output logic                good_o,
  output logic                found_o,
  output logic [TAP_BITS-1:0] win_lo_o,
  output logic [TAP_BITS-1:0] win_hi_o
);

  localparam int CW = (SAMPLES > 2) ? $clog2(SAMPLES) : 1;

  logic                active_q;
  logic                have_ref_q;
  logic [DW-1:0]       ref_q;
  logic [CW-1:0]       cnt_q;
  logic                good_q;
  logic                done_q;
  logic                res_q;
  logic                found_q;
  logic [TAP_BITS-1:0] lo_q;
  logic [TAP_BITS-1:0] hi_q;

  logic w_last;
  logic w_tap_good;

  assign w_last     = (cnt_q == CW'(SAMPLES - 2));
  assign w_tap_good = good_q & (word_i == ref_q);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      active_q   <= 1'b0;
      have_ref_q <= 1'b0;
      ref_q      <= '0;
      cnt_q      <= '0;
      good_q     <= 1'b0;
      done_q     <= 1'b0;
      res_q      <= 1'b0;
      found_q    <= 1'b0;
      lo_q       <= '0;
      hi_q       <= '0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        // The start cycle itself may already carry the reference word.
        active_q   <= 1'b1;
        have_ref_q <= valid_i;
        ref_q      <= word_i;
        cnt_q      <= '0;
        good_q     <= 1'b1;
        if (clear_i) begin
          found_q <= 1'b0;
          lo_q    <= '0;
          hi_q    <= '0;
        end
      end else if (active_q && valid_i) begin
        if (!have_ref_q) begin
          ref_q      <= word_i;
          have_ref_q <= 1'b1;
        end else begin
          good_q <= w_tap_good;
          cnt_q  <= cnt_q + 1'b1;
          if (w_last) begin
            active_q <= 1'b0;
            done_q   <= 1'b1;
            res_q    <= w_tap_good;
            if (w_tap_good) begin
              if (!found_q) lo_q <= tap_i;
              hi_q    <= tap_i;
              found_q <= 1'b1;
            end
          end
        end
      end
    end
  end

  assign done_o   = done_q;
  assign good_o   = res_q;
  assign found_o  = found_q;
  assign win_lo_o = lo_q;
  assign win_hi_o = hi_q;

endmodule
`default_nettype wire

// File: rtl/s7_iserdes_align.sv
`default_nettype none
// ============================================================================
// s7_iserdes_align : per-lane IDELAY eye scan, eye centring and bitslip lock
// Revision         : 1.0
// ============================================================================
module s7_iserdes_align
  import s7_iserdes_pkg::*;
#(
  parameter int             N_LANES  = 8,
  parameter int             DW       = 8,
  parameter logic [DW-1:0]  PATTERN  = DW'(DEF_PATTERN),
  parameter int             TAP_BITS = DEF_TAP_BITS,
  parameter int             SAMPLES  = 64,
  parameter int             SETTLE   = DEF_SETTLE
) (
  input  logic                         sys_clk_i,
  input  logic                         sys_rst_i,
  input  logic                         start_i,
  input  logic                         data_valid_i,
  input  logic [N_LANES*DW-1:0]        data_in_i,
  input  logic [N_LANES*TAP_BITS-1:0]  id_value_i,
  output logic [N_LANES-1:0]           id_inc_o,
  output logic [N_LANES-1:0]           id_dec_o,
  output logic [N_LANES-1:0]           bitslip_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic [N_LANES-1:0]           locked_o,
  output logic [N_LANES-1:0]           fail_o
);

  localparam int LW = (N_LANES > 1) ? $clog2(N_LANES) : 1;
  localparam int WW = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;
  localparam int SW = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [TAP_BITS-1:0] TAP_MAX = {TAP_BITS{1'b1}};

  state_t              state_q;
  state_t              ret_q;
  logic [LW-1:0]       lane_q;
  logic [TAP_BITS-1:0] tap_q;
  logic [SW-1:0]       slip_q;
  logic [WW-1:0]       wait_q;
  logic                busy_q;
  logic                done_q;
  logic [N_LANES-1:0]  locked_q;
  logic [N_LANES-1:0]  fail_q;
  logic [N_LANES-1:0]  id_inc_q;
  logic [N_LANES-1:0]  id_dec_q;
  logic [N_LANES-1:0]  bitslip_q;
  logic                scan_start_q;
  logic                win_clr_q;

  logic [DW-1:0]       w_word;
  logic [TAP_BITS-1:0] w_tap;
  logic                es_done;
  logic                es_good;
  logic                es_found;
  logic [TAP_BITS-1:0] es_lo;
  logic [TAP_BITS-1:0] es_hi;
  logic [TAP_BITS:0]   w_mid;
  logic [TAP_BITS:0]   w_cur;

  always_comb begin
    w_word = '0;
    w_tap  = '0;
    for (int k = 0; k < N_LANES; k++) begin
      if (LW'(k) == lane_q) begin
        w_word = data_in_i[k*DW +: DW];
        w_tap  = id_value_i[k*TAP_BITS +: TAP_BITS];
      end
    end
  end

  // Centre is formed one bit wider so win_lo+win_hi cannot wrap.
  assign w_mid = ({1'b0, es_lo} + {1'b0, es_hi}) >> 1;
  assign w_cur = {1'b0, w_tap};

  s7_iserdes_eye_scan #(
    .DW       (DW),
    .TAP_BITS (TAP_BITS),
    .SAMPLES  (SAMPLES)
  ) u_eye_scan (
    .clk_i    (sys_clk_i),
    .rst_i    (sys_rst_i),
    .start_i  (scan_start_q),
    .clear_i  (win_clr_q),
    .valid_i  (data_valid_i),
    .word_i   (w_word),
    .tap_i    (tap_q),
    .done_o   (es_done),
    .good_o   (es_good),
    .found_o  (es_found),
    .win_lo_o (es_lo),
    .win_hi_o (es_hi)
  );

  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      state_q      <= S_IDLE;
      ret_q        <= S_IDLE;
      lane_q       <= '0;
      tap_q        <= '0;
      slip_q       <= '0;
      wait_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      locked_q     <= '0;
      fail_q       <= '0;
      id_inc_q     <= '0;
      id_dec_q     <= '0;
      bitslip_q    <= '0;
      scan_start_q <= 1'b0;
      win_clr_q    <= 1'b0;
    end else begin
      id_inc_q     <= '0;
      id_dec_q     <= '0;
      bitslip_q    <= '0;
      done_q       <= 1'b0;
      scan_start_q <= 1'b0;
      win_clr_q    <= 1'b0;
      wait_q       <= '0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            locked_q <= '0;
            fail_q   <= '0;
            busy_q   <= 1'b1;
            lane_q   <= '0;
            state_q  <= S_ZERO;
          end
        end
        S_ZERO: begin
          if (w_tap != '0) begin
            id_dec_q[lane_q] <= 1'b1;
            ret_q            <= S_ZERO;
            state_q          <= S_WAIT;
          end else begin
            tap_q        <= '0;
            scan_start_q <= 1'b1;
            win_clr_q    <= 1'b1;
            state_q      <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (es_done) begin
            if (!es_good && es_found) begin
              state_q <= S_CENTER;
            end else if (tap_q != TAP_MAX) begin
              id_inc_q[lane_q] <= 1'b1;
              tap_q            <= tap_q + 1'b1;
              ret_q            <= S_SCAN;
              state_q          <= S_WAIT;
            end else begin
              state_q <= S_CENTER;
            end
          end
        end
        S_CENTER: begin
          if (!es_found) begin
            fail_q[lane_q] <= 1'b1;
            state_q        <= S_NEXT;
          end else if (w_cur > w_mid) begin
            id_dec_q[lane_q] <= 1'b1;
            ret_q            <= S_CENTER;
            state_q          <= S_WAIT;
          end else if (w_cur < w_mid) begin
            id_inc_q[lane_q] <= 1'b1;
            ret_q            <= S_CENTER;
            state_q          <= S_WAIT;
          end else begin
            slip_q  <= '0;
            state_q <= S_SLIP;
          end
        end
        S_SLIP: begin
          if (data_valid_i) begin
            if (w_word == PATTERN) begin
              locked_q[lane_q] <= 1'b1;
              state_q          <= S_NEXT;
            end else if (slip_q != SW'(DW - 1)) begin
              bitslip_q[lane_q] <= 1'b1;
              slip_q            <= slip_q + 1'b1;
              ret_q             <= S_SLIP;
              state_q           <= S_WAIT;
            end else begin
              fail_q[lane_q] <= 1'b1;
              state_q        <= S_NEXT;
            end
          end
        end
        S_WAIT: begin
          // The pulse cycle is the first of the SETTLE wait cycles.
          if (wait_q == WW'(SETTLE - 1)) begin
            state_q <= ret_q;
            if (ret_q == S_SCAN) scan_start_q <= 1'b1;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        S_NEXT: begin
          if (lane_q == LW'(N_LANES - 1)) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            lane_q  <= lane_q + 1'b1;
            state_q <= S_ZERO;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign id_inc_o  = id_inc_q;
  assign id_dec_o  = id_dec_q;
  assign bitslip_o = bitslip_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign locked_o  = locked_q;
  assign fail_o    = fail_q;

endmodule
`default_nettype wire
